// File: rtl/key_pulser_if.sv
// Key bundle between the raw push-button pins and the debounced pulse outputs.
// The master side drives the buttons; the slave side (the debouncer) drives the results.
interface key_pulser_if;
    logic [3:0] KEY_N;
    logic [3:0] KEY;
    logic [3:0] key_rel;
    logic [3:0] key_level;

    modport master (
        output KEY_N,
        input  KEY,
        input  key_rel,
        input  key_level
    );

    modport slave (
        input  KEY_N,
        output KEY,
        output key_rel,
        output key_level
    );
endinterface

// File: rtl/key_pulser.sv
// Four independent push-button debouncers: 2-flop synchronizer, registered inversion,
// stability counter, debounced level and one-cycle press/release pulses per key.
module key_pulser #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic         CLOCK_50,
    input  logic         reset_n,
    key_pulser_if.slave  kp
);

    localparam int NKEYS = 4;
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES < 1 || longint'(DEBOUNCE_CYCLES) > (longint'(1) << CNT_W)) begin : g_cfg_err
            $error("key_pulser: DEBOUNCE_CYCLES out of range for CNT_W");
        end
    endgenerate

    logic [NKEYS-1:0] sync_p0;
    logic [NKEYS-1:0] sync_p1;
    logic [NKEYS-1:0] pressed_p2;
    logic [NKEYS-1:0] key_level_q;
    logic [NKEYS-1:0] press_q;
    logic [NKEYS-1:0] rel_q;
    logic [NKEYS-1:0] mismatch;
    logic [NKEYS-1:0] term;
    logic [CNT_W-1:0] cnt_q [NKEYS];

    // A key is accepted on the edge where it has disagreed with its level long enough.
    always_comb begin
        mismatch = pressed_p2 ^ key_level_q;
        term     = '0;
        for (int i = 0; i < NKEYS; i++) begin
            term[i] = mismatch[i] && (cnt_q[i] == CNT_TERM);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            sync_p0     <= '1;
            sync_p1     <= '1;
            pressed_p2  <= '0;
            key_level_q <= '0;
            press_q     <= '0;
            rel_q       <= '0;
            for (int i = 0; i < NKEYS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            // p0/p1: metastability synchronizer on the raw pins
            sync_p0    <= kp.KEY_N;
            sync_p1    <= sync_p0;
            // p2: active-high pressed view of the synchronized pins
            pressed_p2 <= ~sync_p1;

            key_level_q <= key_level_q ^ term;
            press_q     <= term & ~key_level_q;
            rel_q       <= term & key_level_q;

            // Any sample agreeing with the level is a bounce and restarts the count.
            for (int i = 0; i < NKEYS; i++) begin
                if (!mismatch[i] || term[i]) begin
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign kp.KEY       = press_q;
    assign kp.key_rel   = rel_q;
    assign kp.key_level = key_level_q;

endmodule

// File: doc/key_pulser.md
KEY_PULSER -- requirements
Module: key_pulser

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, number of consecutive stable synchronized samples required to accept a key change (1 ms at 50 MHz); legal range 1..2^CNT_W.
REQ-002 Parameter CNT_W, default 16, width of each per-key debounce counter.
REQ-003 CLOCK_50  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on CLOCK_50 rising edge.
REQ-005 KEY_N  input  4  raw asynchronous push-buttons, active-low (0 = pressed).
REQ-006 KEY  output  4  registered press pulses, active-high, one cycle per accepted press; directly drives KEY-consuming state machines.
REQ-007 key_rel  output  4  registered release pulses, active-high, one cycle per accepted release.
REQ-008 key_level  output  4  registered debounced level, 1 = pressed.

Function
REQ-009 Each KEY_N bit SHALL pass through a dedicated 2-flop synchronizer before any other logic uses it; synchronized value inverted to active-high "pressed".
REQ-010 Keys SHALL be processed independently: one synchronizer, counter, level register and pulse pair per bit; no cross-key priority or masking.
REQ-011 Per key, each cycle: synchronized pressed == key_level -> counter cleared to 0; else counter increments by 1.
REQ-012 When synchronized pressed != key_level and counter == DEBOUNCE_CYCLES-1, key_level SHALL toggle on that edge and counter SHALL clear to 0.
REQ-013 Net acceptance latency: key_level changes on the rising edge 2+DEBOUNCE_CYCLES edges after the edge that first samples the new KEY_N value, provided it stays stable throughout.
REQ-014 Any synchronized sample equal to key_level (bounce) SHALL restart the count from 0; changes shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no output activity.
REQ-015 KEY[i] SHALL be 1 for exactly the one cycle following the edge on which key_level[i] goes 0->1; 0 at all other times.
REQ-016 key_rel[i] SHALL be 1 for exactly the one cycle following the edge on which key_level[i] goes 1->0; 0 at all other times.
REQ-017 KEY[i] and key_rel[i] SHALL never be 1 in the same cycle; a held key SHALL produce exactly one KEY pulse regardless of hold length (no auto-repeat).
REQ-018 Multiple keys accepted on the same edge SHALL pulse in the same cycle (e.g. KEY = 4'b1111).
REQ-019 Counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap; CNT_W too small for DEBOUNCE_CYCLES is a configuration error.
REQ-020 DEBOUNCE_CYCLES = 1: key_level follows synchronized input with one cycle extra delay; pulses still one cycle wide.

Reset
REQ-021 While reset_n = 0 at a rising edge: synchronizer flops set to 1 (released), counters 0, key_level 4'b0000, KEY 4'b0000, key_rel 4'b0000.
REQ-022 Reset asserted mid-count SHALL discard partial progress; after reset_n returns to 1, debouncing restarts from count 0.
REQ-023 Key held pressed through reset release SHALL be accepted as a new press (one KEY pulse) after full latency per REQ-013.
REQ-024 No output SHALL depend combinationally on KEY_N or reset_n.

Verification (DEBOUNCE_CYCLES = 4)
REQ-025 Clean press: KEY_N[0] driven 0 and held 20 cycles -> key_level[0] rises and KEY[0] = 1 for one cycle, 6 edges after first low sample; no further KEY activity.
REQ-026 Bounce: KEY_N[1] low 3, high 1, low 3, high 1, then low held -> no KEY[1] until 4 consecutive low synchronized samples; exactly one pulse.
REQ-027 Glitch: KEY_N[2] low for 3 cycles then high -> KEY, key_rel, key_level all remain 0.
REQ-028 Release: after REQ-025, KEY_N[0] returns to 1 -> key_rel[0] = 1 for one cycle 6 edges later, key_level[0] falls, KEY[0] stays 0.
REQ-029 Simultaneous: KEY_N = 4'b0000 driven on one edge -> KEY = 4'b1111 for exactly one cycle, then 4'b0000.
REQ-030 Reset mid-debounce: KEY_N[3] low, reset_n = 0 for 1 cycle when counter = 2, key still held -> all outputs 0 during reset; single KEY[3] pulse 6 edges after reset release.
